cpu_phase_controller: RTL and testbench

- Eight-phase instruction sequencer for the 8-bit RISC CPU.
- Each instruction runs through a fixed cycle of eight clock phases. In each phase the block decodes the current phase, the instruction register opcode and the accumulator zero flag into the datapath strobes: address-mux select, memory read/write, IR load, accumulator load, program counter load/increment, data bus enable and halt.
- It is the only driver of the program counter's load and inc inputs.
- A memory wait handshake on fetch phases and a sticky halt state complete the block.

---
 rtl/cpu_phase_controller.sv | 137 +++++++++++++
 tb/tb_cpu_phase_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_controller.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU.
// Decodes phase, opcode and zero flag into datapath strobes; sticky halt until reset.
module cpu_phase_controller #(
  parameter int unsigned WIDTH_OPCODE = 3,
  parameter logic [WIDTH_OPCODE-1:0] OP_HLT = WIDTH_OPCODE'(0),
  parameter logic [WIDTH_OPCODE-1:0] OP_SKZ = WIDTH_OPCODE'(1),
  parameter logic [WIDTH_OPCODE-1:0] OP_ADD = WIDTH_OPCODE'(2),
  parameter logic [WIDTH_OPCODE-1:0] OP_AND = WIDTH_OPCODE'(3),
  parameter logic [WIDTH_OPCODE-1:0] OP_XOR = WIDTH_OPCODE'(4),
  parameter logic [WIDTH_OPCODE-1:0] OP_LDA = WIDTH_OPCODE'(5),
  parameter logic [WIDTH_OPCODE-1:0] OP_STO = WIDTH_OPCODE'(6),
  parameter logic [WIDTH_OPCODE-1:0] OP_JMP = WIDTH_OPCODE'(7)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    sel,
  output logic                    rd,
  output logic                    wr,
  output logic                    ld_ir,
  output logic                    ld_ac,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    data_e,
  output logic                    halt,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop, is_hlt, is_skz, is_sto, is_jmp;

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase and strobe decode; a halted sequencer freezes at OP_ADDR.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    ld_ir    = 1'b0;
    ld_ac    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel     = 1'b1;
          phase_d = PH_INST_FETCH;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
          if (mem_ready) phase_d = PH_INST_LOAD;
        end
        PH_INST_LOAD: begin
          sel     = 1'b1;
          rd      = 1'b1;
          ld_ir   = 1'b1;
          phase_d = PH_IDLE;
        end
        PH_IDLE: begin
          sel     = 1'b1;
          rd      = 1'b1;
          ld_ir   = 1'b1;
          phase_d = PH_OP_ADDR;
        end
        PH_OP_ADDR: begin
          if (is_hlt) begin
            halt     = 1'b1;
            halted_d = 1'b1;
          end else begin
            inc_pc  = 1'b1;
            phase_d = PH_OP_FETCH;
          end
        end
        PH_OP_FETCH: begin
          rd = aluop;
          if (!aluop || mem_ready) phase_d = PH_ALU_OP;
        end
        PH_ALU_OP: begin
          rd      = aluop;
          inc_pc  = is_skz && zero;
          ld_pc   = is_jmp;
          data_e  = is_sto;
          phase_d = PH_STORE;
        end
        PH_STORE: begin
          rd      = aluop;
          ld_ac   = aluop;
          inc_pc  = is_jmp;
          ld_pc   = is_jmp;
          wr      = is_sto;
          data_e  = is_sto;
          phase_d = PH_INST_ADDR;
        end
        default: phase_d = PH_INST_ADDR;
      endcase
    end
  end

  assign phase = 3'(phase_q);

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Self-checking bench for cpu_phase_controller: a per-cycle reference model pushes
// expected strobe vectors to a scoreboard queue, popped when the outputs settle.
module tb_cpu_phase_controller;

  logic       clk, reset, zero, mem_ready;
  logic [2:0] opcode;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;
  int pc_incs, pc_loads, wr_rd_clash;

  logic [2:0]  m_phase;
  logic        m_halted;
  logic [11:0] exp_q[$];

  cpu_phase_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase};
  endfunction

  // Expected {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt,phase}
  function automatic logic [11:0] exp_out(input logic [2:0] ph, input logic hs,
                                          input logic [2:0] op, input logic z);
    logic s, r, w, li, la, ip, lp, de, h, alu;
    alu = (op >= 3'd2) && (op <= 3'd5);
    {s, r, w, li, la, ip, lp, de, h} = 9'b0;
    if (hs) h = 1'b1;
    else case (ph)
      3'd0: s = 1'b1;
      3'd1: begin s = 1'b1; r = 1'b1; end
      3'd2, 3'd3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
      3'd4: if (op == 3'd0) h = 1'b1; else ip = 1'b1;
      3'd5: r = alu;
      3'd6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
      default: begin
        r = alu; la = alu; ip = (op == 3'd7); lp = (op == 3'd7);
        w = (op == 3'd6); de = (op == 3'd6);
      end
    endcase
    return {s, r, w, li, la, ip, lp, de, h, hs ? 3'd4 : ph};
  endfunction

  task automatic model_reset();
    m_phase  = 3'd0;
    m_halted = 1'b0;
  endtask

  // One clock: drive inputs at negedge, score settled outputs, advance model at posedge.
  task automatic cycle(input logic [2:0] op, input logic z, input logic mr);
    logic [11:0] e;
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    exp_q.push_back(exp_out(m_phase, m_halted, op, z));
    #1;
    e = exp_q.pop_front();
    check_eq($sformatf("cyc_ph%0d_op%0d", m_phase, op), 32'(outs()), 32'(e));
    if (inc_pc && !ld_pc) pc_incs++;
    if (ld_pc) pc_loads++;
    if (rd && wr) wr_rd_clash++;
    if (!m_halted) begin
      if (m_phase == 3'd4 && op == 3'd0) m_halted = 1'b1;
      else if (m_phase == 3'd1 && !mr) m_phase = m_phase;
      else if (m_phase == 3'd5 && !mr && op >= 3'd2 && op <= 3'd5) m_phase = m_phase;
      else m_phase = m_phase + 3'd1;
    end
    @(posedge clk);
  endtask

  // Run one full instruction from phase 0 back to phase 0; returns cycle count.
  task automatic run_instr(input logic [2:0] op, input logic z, input int s1, input int s5,
                           output int cycles);
    logic mr;
    cycles = 0; pc_incs = 0; pc_loads = 0;
    do begin
      mr = 1'b1;
      if (m_phase == 3'd1 && s1 > 0) begin mr = 1'b0; s1--; end
      else if (m_phase == 3'd5 && s5 > 0) begin mr = 1'b0; s5--; end
      cycle(op, z, mr);
      cycles++;
    end while (m_phase != 3'd0 && cycles < 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    reset = 1'b1; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1;
    wr_rd_clash = 0;
    model_reset();
    #3 check_eq("reset_outs", 32'(outs()), 32'h800);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(3'd2, 1'b0, 0, 0, len);       // ADD
    check_eq("add_len", 32'(len), 32'd8);
    check_eq("add_pc_incs", 32'(pc_incs), 32'd1);

    run_instr(3'd7, 1'b0, 0, 0, len);       // JMP
    check_eq("jmp_len", 32'(len), 32'd8);
    check_eq("jmp_pc_loads", 32'(pc_loads), 32'd2);

    run_instr(3'd6, 1'b0, 0, 0, len);       // STO
    check_eq("sto_len", 32'(len), 32'd8);

    run_instr(3'd1, 1'b1, 0, 0, len);       // SKZ taken
    check_eq("skz1_pc_incs", 32'(pc_incs), 32'd2);
    run_instr(3'd1, 1'b0, 0, 0, len);       // SKZ not taken
    check_eq("skz0_pc_incs", 32'(pc_incs), 32'd1);

    run_instr(3'd5, 1'b0, 3, 2, len);       // LDA with stalls
    check_eq("lda_stall_len", 32'(len), 32'd13);

    run_instr(3'd7, 1'b0, 0, 5, len);       // non-ALU op ignores phase-5 wait
    check_eq("jmp_nostall_len", 32'(len), 32'd8);

    // HLT: enter halt, then toggle inputs while halted
    pc_incs = 0;
    repeat (5) cycle(3'd0, 1'b0, 1'b1);
    check_eq("hlt_pc_incs", 32'(pc_incs), 32'd0);
    for (int i = 0; i < 8; i++)
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #2 reset = 1'b1;
    model_reset();
    #1 check_eq("hlt_reset_outs", 32'(outs()), 32'h800);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(3'd3, 1'b0, 1, 1, len);       // AND after halt recovery
    check_eq("and_len", 32'(len), 32'd10);

    // Async reset mid-phase-6 of a JMP
    for (int i = 0; i < 6; i++) cycle(3'd7, 1'b0, 1'b1);
    #2 check_eq("jmp_ph6_ldpc", 32'(ld_pc), 32'd1);
    reset = 1'b1;
    model_reset();
    #1 check_eq("mid_reset_ldpc", 32'(ld_pc), 32'd0);
    check_eq("mid_reset_outs", 32'(outs()), 32'h800);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(3'd4, 1'b0, 0, 0, len);       // XOR restart
    check_eq("xor_len", 32'(len), 32'd8);
    check_eq("rd_wr_clash", 32'(wr_rd_clash), 32'd0);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
